// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned MD_DEFAULT_SIZE = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_SIGN
  } md_state_e;

  function automatic int unsigned md_cnt_w(input int unsigned size);
    return $clog2(size);
  endfunction

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for multiply, restoring subtract-shift for divide.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_SIZE = MD_DEFAULT_SIZE
) (
  input  logic                 is_div_i,
  input  logic [DATA_SIZE:0]   p_i,
  input  logic [DATA_SIZE-1:0] q_i,
  input  logic [DATA_SIZE-1:0] m_i,
  output logic [DATA_SIZE:0]   p_o,
  output logic [DATA_SIZE-1:0] q_o
);

  logic [DATA_SIZE:0]   sum;
  logic [DATA_SIZE:0]   shifted;
  logic [DATA_SIZE+1:0] diff;

  always_comb begin
    sum     = q_i[0] ? (p_i + {1'b0, m_i}) : p_i;
    shifted = {p_i[DATA_SIZE-1:0], q_i[DATA_SIZE-1]};
    // Extra top bit makes the trial subtraction's sign the borrow-out.
    diff    = {1'b0, shifted} - {2'b00, m_i};
    if (is_div_i) begin
      if (!diff[DATA_SIZE+1]) begin
        p_o = diff[DATA_SIZE:0];
        q_o = {q_i[DATA_SIZE-2:0], 1'b1};
      end else begin
        p_o = shifted;
        q_o = {q_i[DATA_SIZE-2:0], 1'b0};
      end
    end else begin
      p_o = {1'b0, sum[DATA_SIZE:1]};
      q_o = {sum[0], q_i[DATA_SIZE-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative mult/multu/div/divu unit with HI/LO registers and Start/Busy/Done handshake.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_SIZE = MD_DEFAULT_SIZE
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Start,
  input  logic [1:0]           Op,
  input  logic [DATA_SIZE-1:0] SrcA,
  input  logic [DATA_SIZE-1:0] SrcB,
  input  logic                 HiWrite,
  input  logic                 LoWrite,
  input  logic [DATA_SIZE-1:0] WriteData,
  output logic                 Busy,
  output logic                 Done,
  output logic [DATA_SIZE-1:0] Hi,
  output logic [DATA_SIZE-1:0] Lo,
  output logic                 Unvalid
);

  localparam int unsigned CNT_W = md_cnt_w(DATA_SIZE);

  md_state_e              state_q, state_d;
  md_op_e                 op_q, op_d;
  logic [DATA_SIZE-1:0]   a_q, a_d, b_q, b_d;
  logic [DATA_SIZE:0]     p_q, p_d;
  logic [DATA_SIZE-1:0]   q_q, q_d, m_q, m_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   neg_prod_q, neg_prod_d;
  logic                   neg_quo_q, neg_quo_d;
  logic                   neg_rem_q, neg_rem_d;
  logic [DATA_SIZE-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                   done_q, done_d;
  logic                   unvalid_q, unvalid_d;

  logic                   is_div;
  logic                   is_signed;
  logic [DATA_SIZE-1:0]   abs_a, abs_b;
  logic [2*DATA_SIZE-1:0] prod;
  logic [DATA_SIZE:0]     step_p;
  logic [DATA_SIZE-1:0]   step_q;

  muldiv_step #(
    .DATA_SIZE (DATA_SIZE)
  ) u_step (
    .is_div_i (is_div),
    .p_i      (p_q),
    .q_i      (q_q),
    .m_i      (m_q),
    .p_o      (step_p),
    .q_o      (step_q)
  );

  always_comb begin
    is_div     = md_is_div(op_q);
    is_signed  = (op_q == MD_MULT) || (op_q == MD_DIV);
    abs_a      = (is_signed && a_q[DATA_SIZE-1]) ? -a_q : a_q;
    abs_b      = (is_signed && b_q[DATA_SIZE-1]) ? -b_q : b_q;
    prod       = {p_q[DATA_SIZE-1:0], q_q};

    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    p_d        = p_q;
    q_d        = q_q;
    m_d        = m_q;
    cnt_d      = cnt_q;
    neg_prod_d = neg_prod_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    unvalid_d  = unvalid_q;

    case (state_q)
      S_IDLE: begin
        // Start wins over a same-cycle mthi/mtlo.
        if (Start) begin
          op_d    = md_op_e'(Op);
          a_d     = SrcA;
          b_d     = SrcB;
          state_d = S_LOAD;
        end else begin
          if (HiWrite) hi_d = WriteData;
          if (LoWrite) lo_d = WriteData;
        end
      end
      S_LOAD: begin
        neg_prod_d = (op_q == MD_MULT) && (a_q[DATA_SIZE-1] ^ b_q[DATA_SIZE-1]);
        neg_quo_d  = (op_q == MD_DIV)  && (a_q[DATA_SIZE-1] ^ b_q[DATA_SIZE-1]);
        neg_rem_d  = (op_q == MD_DIV)  && a_q[DATA_SIZE-1];
        if (is_div && (b_q == '0)) begin
          hi_d      = '0;
          lo_d      = '0;
          unvalid_d = 1'b1;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end else begin
          p_d     = '0;
          q_d     = is_div ? abs_a : abs_b;
          m_d     = is_div ? abs_b : abs_a;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        p_d   = step_p;
        q_d   = step_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_SIZE - 1)) state_d = S_SIGN;
      end
      S_SIGN: begin
        if (is_div) begin
          lo_d = neg_quo_q ? -q_q : q_q;
          hi_d = neg_rem_q ? -p_q[DATA_SIZE-1:0] : p_q[DATA_SIZE-1:0];
        end else begin
          {hi_d, lo_d} = neg_prod_q ? -prod : prod;
        end
        unvalid_d = 1'b0;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      op_q       <= MD_MULT;
      a_q        <= '0;
      b_q        <= '0;
      p_q        <= '0;
      q_q        <= '0;
      m_q        <= '0;
      cnt_q      <= '0;
      neg_prod_q <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      unvalid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      p_q        <= p_d;
      q_q        <= q_d;
      m_q        <= m_d;
      cnt_q      <= cnt_d;
      neg_prod_q <= neg_prod_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      unvalid_q  <= unvalid_d;
    end
  end

  assign Busy    = (state_q != S_IDLE);
  assign Done    = done_q;
  assign Hi      = hi_q;
  assign Lo      = lo_q;
  assign Unvalid = unvalid_q;

endmodule
